// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard peripheral: receiver FSM states,
// register word offsets and status register bit positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2State_t;

    localparam logic [15:0] REG_DATA   = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVF       = 1;
    localparam int STAT_PERR      = 2;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous scan-code FIFO with full/empty flags. A pop and a push in the
// same cycle are both honoured even when the FIFO is full.
module ps2_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head     = r_mem[r_rdPtr];
    assign w_doPop    = i_pop && !o_empty;
    // When full, a simultaneous pop frees the head slot that the push then reuses.
    assign w_doPush   = i_push && (!o_full || w_doPop);
    assign o_overflow = i_push && o_full && !w_doPop;

    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard_io.sv
// PS/2 keyboard receiver with a memory-mapped data/status register pair and
// scan-code FIFO. Define PS2_PARITY_CHECK_EN to enable odd-parity checking.
module ps2_keyboard_io
    import ps2_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'hFF10,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          FILTER_CYCLES  = 8,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic [15:0] raddr,
    input  logic        ren,
    output logic [15:0] rdata,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        wenable,
    output logic        irq
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   ADDR_DATA    = BASE_ADDR + REG_DATA;
    localparam logic [15:0]   ADDR_STATUS  = BASE_ADDR + REG_STATUS;

    logic          r_clkMeta, r_clkSync, r_datMeta, r_datSync;
    logic          r_filtLevel;
    logic [FW-1:0] r_filtCnt;
    logic [TW-1:0] r_toCnt;
    ps2State_t     r_state, r_stateNext;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;
    logic          r_pushValid;
    logic [7:0]    r_pushData;
    logic          r_ovf;
    logic          w_fallEdge, w_timeout, w_accept, w_parityOk, w_perr;
    logic          w_pop, w_full, w_empty, w_overflow, w_statusWr;
    logic [7:0]    w_head;
    logic [15:0]   w_status;
    logic          w_unused;

    // Lines idle high, so the synchronisers and filter come out of reset at 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clkMeta <= 1'b1;
            r_clkSync <= 1'b1;
            r_datMeta <= 1'b1;
            r_datSync <= 1'b1;
        end else begin
            r_clkMeta <= ps2_clk;
            r_clkSync <= r_clkMeta;
            r_datMeta <= ps2_dat;
            r_datSync <= r_datMeta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_filtLevel <= 1'b1;
            r_filtCnt   <= '0;
        end else if (r_clkSync == r_filtLevel) begin
            r_filtCnt <= '0;
        end else if (r_filtCnt == FILTER_LAST) begin
            r_filtLevel <= r_clkSync;
            r_filtCnt   <= '0;
        end else begin
            r_filtCnt <= r_filtCnt + 1'b1;
        end
    end

    assign w_fallEdge = r_filtLevel && !r_clkSync && (r_filtCnt == FILTER_LAST);
    assign w_timeout  = (r_state != IDLE) && !w_fallEdge && (r_toCnt == TIMEOUT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_toCnt <= '0;
        end else if ((r_state == IDLE) || w_fallEdge) begin
            r_toCnt <= '0;
        end else begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= r_stateNext;
        end
    end

    always_comb begin
        r_stateNext = r_state;
        w_accept    = 1'b0;
        if (w_timeout) begin
            r_stateNext = IDLE;
        end else if (w_fallEdge) begin
            case (r_state)
                IDLE:   if (!r_datSync) r_stateNext = DATA;
                DATA:   if (r_bitCnt == 3'd7) r_stateNext = PARITY;
                PARITY: r_stateNext = STOP;
                STOP: begin
                    r_stateNext = IDLE;
                    w_accept    = r_datSync && w_parityOk;
                end
                default: r_stateNext = IDLE;
            endcase
        end
    end

    // The accepted byte is registered so it reaches the FIFO one cycle after the stop edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_pushValid <= 1'b0;
            r_pushData  <= '0;
        end else begin
            r_pushValid <= w_accept;
            if (w_accept) begin
                r_pushData <= r_shift;
            end
            if (w_fallEdge) begin
                if (r_state == IDLE) begin
                    r_bitCnt <= '0;
                end else if (r_state == DATA) begin
                    r_shift  <= {r_datSync, r_shift[7:1]};
                    r_bitCnt <= r_bitCnt + 1'b1;
                end
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;
    logic r_perr;
    logic w_perrSet;
    logic w_perrClr;

    assign w_parityOk = ^{r_shift, r_parity};
    assign w_perrSet  = w_fallEdge && (r_state == STOP) && !w_parityOk;
    assign w_perrClr  = w_statusWr && wdata[2];
    assign w_perr     = r_perr;
    assign w_unused   = ^{wdata[15:3], wdata[0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            if (w_fallEdge && (r_state == PARITY)) begin
                r_parity <= r_datSync;
            end
            if (w_perrSet) begin
                r_perr <= 1'b1;
            end else if (w_perrClr) begin
                r_perr <= 1'b0;
            end
        end
    end
`else
    assign w_parityOk = 1'b1;
    assign w_perr     = 1'b0;
    assign w_unused   = ^{wdata[15:2], wdata[0]};
`endif

    assign w_pop      = ren && (raddr == ADDR_DATA) && !w_empty;
    assign w_statusWr = wenable && (waddr == ADDR_STATUS);

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (r_pushValid),
        .i_pushData (r_pushData),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_overflow) begin
            r_ovf <= 1'b1;
        end else if (w_statusWr && wdata[1]) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STAT_NOT_EMPTY] = !w_empty;
        w_status[STAT_OVF]       = r_ovf;
        w_status[STAT_PERR]      = w_perr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (ren) begin
            if (raddr == ADDR_DATA) begin
                rdata <= w_empty ? 16'h0000 : {8'h00, w_head};
            end else if (raddr == ADDR_STATUS) begin
                rdata <= w_status;
            end else begin
                rdata <= 16'h0000;
            end
        end
    end

    assign irq = !w_empty;

endmodule
